// File: rtl/fp_addsub_pipe_if.sv
// Streaming operand/result bundle for the pipelined FP adder/subtractor.
// An operand pair moves in on a clock edge where in_valid & in_ready are both high.
// A result moves out on an edge where out_valid & out_ready are both high.
// The producer holds valid and data stable until the transfer happens.
interface fp_addsub_pipe_if #(
    parameter int E_size     = 8,
    parameter int M_size     = 23,
    parameter int total_size = 1 + E_size + M_size
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [total_size-1:0] A;
    logic [total_size-1:0] B;
    logic                  op_sub;
    logic                  out_valid;
    logic                  out_ready;
    logic [total_size-1:0] SUM;
    logic [3:0]            flags;

    modport master (
        output in_valid, A, B, op_sub, out_ready,
        input  in_ready, out_valid, SUM, flags
    );

    modport slave (
        input  in_valid, A, B, op_sub, out_ready,
        output in_ready, out_valid, SUM, flags
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Three-stage FP add/subtract: S1 unpack/classify/align, S2 significand add,
// S3 normalise/round-to-nearest-even/pack. Global stall, FTZ, flags {invalid, overflow, underflow, inexact}.
module fp_addsub_pipe #(
    parameter int E_size     = 8,
    parameter int M_size     = 23,
    parameter int total_size = 1 + E_size + M_size
) (
    input logic             clk,
    input logic             rst_n,
    fp_addsub_pipe_if.slave bus
);
    localparam int W   = M_size + 4;
    localparam int XW  = E_size + 2;
    localparam int LZW = $clog2(W + 1);
    localparam logic [E_size-1:0]     EXP_ONES = '1;
    localparam logic [total_size-1:0] QNAN     = {1'b0, {E_size{1'b1}}, 1'b1, {(M_size-1){1'b0}}};

    logic adv;
    logic out_valid_q;
    logic [total_size-1:0] sum_q;
    logic [3:0] flags_q;

    assign adv           = !out_valid_q | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.SUM       = sum_q;
    assign bus.flags     = flags_q;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic              sa, sb;
    logic [E_size-1:0] ea, eb;
    logic [M_size-1:0] fa, fb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

    assign sa = bus.A[total_size-1];
    assign sb = bus.B[total_size-1] ^ bus.op_sub;
    assign ea = bus.A[total_size-2 -: E_size];
    assign eb = bus.B[total_size-2 -: E_size];
    assign fa = bus.A[M_size-1:0];
    assign fb = bus.B[M_size-1:0];

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_snan = a_nan && !fa[M_size-1];
    assign b_snan = b_nan && !fb[M_size-1];

    logic                  byp_d;
    logic [total_size-1:0] byp_res_d;
    logic [3:0]            byp_flg_d;

    // Special operands resolve here and ride past the arithmetic untouched.
    always_comb begin
        byp_d     = 1'b1;
        byp_res_d = QNAN;
        byp_flg_d = 4'b0000;
        if (a_nan || b_nan) begin
            byp_flg_d = {a_snan | b_snan, 3'b000};
        end else if (a_inf && b_inf && (sa != sb)) begin
            byp_flg_d = 4'b1000;
        end else if (a_inf) begin
            byp_res_d = {sa, EXP_ONES, {M_size{1'b0}}};
        end else if (b_inf) begin
            byp_res_d = {sb, EXP_ONES, {M_size{1'b0}}};
        end else if (a_zero && b_zero) begin
            byp_res_d = {sa & sb, {(total_size-1){1'b0}}};
        end else if (a_zero) begin
            byp_res_d = {sb, eb, fb};
        end else if (b_zero) begin
            byp_res_d = {sa, ea, fa};
        end else begin
            byp_d = 1'b0;
        end
    end

    logic              b_gt;
    logic              big_s_d;
    logic [E_size-1:0] big_e_d, small_e, diff;
    logic [M_size-1:0] big_f, small_f;
    logic [W-1:0]      big_sig_d, small_ext, shift_mask, small_al_d;

    always_comb begin
        b_gt       = {eb, fb} > {ea, fa};
        big_s_d    = b_gt ? sb : sa;
        big_e_d    = b_gt ? eb : ea;
        small_e    = b_gt ? ea : eb;
        big_f      = b_gt ? fb : fa;
        small_f    = b_gt ? fa : fb;
        diff       = big_e_d - small_e;
        big_sig_d  = {1'b1, big_f, 3'b000};
        small_ext  = {1'b1, small_f, 3'b000};
        // Bits shifted out below S are folded into S; huge shifts leave sticky only.
        shift_mask = ~({W{1'b1}} << diff);
        small_al_d = (small_ext >> diff) | {{(W-1){1'b0}}, |(small_ext & shift_mask)};
    end

    logic                  v1_q, byp1_q, sub1_q, sign1_q;
    logic [total_size-1:0] byp_res1_q;
    logic [3:0]            byp_flg1_q;
    logic [E_size-1:0]     exp1_q;
    logic [W-1:0]          big1_q, small1_q;

    // ---------------- S2: significand add/subtract ----------------
    logic [W:0] sum2_d;
    assign sum2_d = sub1_q ? ({1'b0, big1_q} - {1'b0, small1_q})
                           : ({1'b0, big1_q} + {1'b0, small1_q});

    logic                  v2_q, byp2_q, sign2_q;
    logic [total_size-1:0] byp_res2_q;
    logic [3:0]            byp_flg2_q;
    logic [E_size-1:0]     exp2_q;
    logic [W:0]            sum2_q;

    // ---------------- S3: normalise, round, pack ----------------
    logic [LZW-1:0]          lzc;
    logic [W-1:0]            norm;
    logic signed [XW-1:0]    exp_n, exp_r;
    logic                    g_b, r_b, s_b, round_up, inexact;
    logic [M_size+1:0]       rnd;
    logic [M_size-1:0]       frac_r;
    logic [total_size-1:0]   res_d;
    logic [3:0]              flg_d;

    always_comb begin
        lzc = LZW'(W);
        for (int i = 0; i < W; i++) begin
            if (sum2_q[i]) lzc = LZW'(W - 1 - i);
        end
    end

    always_comb begin
        if (sum2_q[W]) begin
            norm  = sum2_q[W:1] | {{(W-1){1'b0}}, sum2_q[0]};
            exp_n = XW'(exp2_q) + XW'(1);
        end else begin
            norm  = sum2_q[W-1:0] << lzc;
            exp_n = XW'(exp2_q) - XW'(lzc);
        end
        g_b      = norm[2];
        r_b      = norm[1];
        s_b      = norm[0];
        inexact  = g_b | r_b | s_b;
        round_up = g_b & (r_b | s_b | norm[3]);
        rnd      = {1'b0, norm[W-1:3]} + {{(M_size+1){1'b0}}, round_up};
        // A rounding carry means the significand became exactly 2.0.
        if (rnd[M_size+1]) begin
            exp_r  = exp_n + XW'(1);
            frac_r = rnd[M_size:1];
        end else begin
            exp_r  = exp_n;
            frac_r = rnd[M_size-1:0];
        end

        if (byp2_q) begin
            res_d = byp_res2_q;
            flg_d = byp_flg2_q;
        end else if (sum2_q == '0) begin
            res_d = {total_size{1'b0}};
            flg_d = 4'b0000;
        end else if (exp_r >= $signed(XW'(EXP_ONES))) begin
            res_d = {sign2_q, EXP_ONES, {M_size{1'b0}}};
            flg_d = 4'b0101;
        end else if (exp_r <= 0) begin
            res_d = {sign2_q, {(total_size-1){1'b0}}};
            flg_d = 4'b0011;
        end else begin
            res_d = {sign2_q, exp_r[E_size-1:0], frac_r};
            flg_d = {3'b000, inexact};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            flags_q     <= '0;
        end else if (adv) begin
            v1_q       <= bus.in_valid;
            byp1_q     <= byp_d;
            byp_res1_q <= byp_res_d;
            byp_flg1_q <= byp_flg_d;
            sign1_q    <= big_s_d;
            sub1_q     <= sa ^ sb;
            exp1_q     <= big_e_d;
            big1_q     <= big_sig_d;
            small1_q   <= small_al_d;

            v2_q       <= v1_q;
            byp2_q     <= byp1_q;
            byp_res2_q <= byp_res1_q;
            byp_flg2_q <= byp_flg1_q;
            sign2_q    <= sign1_q;
            exp2_q     <= exp1_q;
            sum2_q     <= sum2_d;

            out_valid_q <= v2_q;
            if (v2_q) begin
                sum_q   <= res_d;
                flags_q <= flg_d;
            end
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: latency, special values, rounding, backpressure, mid-flight reset.
module tb_fp_addsub_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_addsub_pipe_if bus ();

    fp_addsub_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam int NV = 20;
    logic [31:0] va[NV], vb[NV], vs[NV];
    logic        vsub[NV];
    logic [3:0]  vf[NV];
    logic [35:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] r, input logic [3:0] f);
        va[i] = a; vb[i] = b; vsub[i] = s; vs[i] = r; vf[i] = f;
    endtask

    task automatic drive_op(input int i);
        bus.in_valid = 1'b1;
        bus.A        = va[i];
        bus.B        = vb[i];
        bus.op_sub   = vsub[i];
    endtask

    task automatic run_stream(input int count, input bit throttle, input string name);
        int issued = 0;
        int retired = 0;
        int cyc = 0;
        bit hold_pend = 1'b0;
        logic [35:0] hold_val = '0;
        logic [35:0] e;
        while (retired < count && cyc < 400) begin
            @(negedge clk);
            bus.out_ready = throttle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (issued < count) drive_op(issued);
            else bus.in_valid = 1'b0;
            #1;
            if (hold_pend) begin
                check_eq({name, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
                check_eq({name, "_hold_data"}, 64'({bus.flags, bus.SUM}), 64'(hold_val));
            end
            hold_pend = 1'b0;
            if (bus.out_valid && !bus.out_ready) begin
                check_eq({name, "_stall_in_ready"}, 64'(bus.in_ready), 64'd0);
                hold_pend = 1'b1;
                hold_val  = {bus.flags, bus.SUM};
            end
            if (bus.out_valid && bus.out_ready) begin
                check_eq({name, "_queue_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq($sformatf("%s_vec%0d", name, retired), 64'({bus.flags, bus.SUM}), 64'(e));
                end
                retired++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back({vf[issued], vs[issued]});
                issued++;
            end
            cyc++;
        end
        check_eq({name, "_retired"}, 64'(retired), 64'(count));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check_eq({name, "_no_extra"}, 64'(bus.out_valid), 64'd0);
        end
        check_eq({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish before 200000");
        $fatal(1);
    end

    initial begin
        set_vec(0,  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
        set_vec(1,  32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
        set_vec(2,  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
        set_vec(3,  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
        set_vec(4,  32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
        set_vec(5,  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
        set_vec(6,  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
        set_vec(7,  32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
        set_vec(8,  32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
        set_vec(9,  32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 4'b0000);
        set_vec(10, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
        set_vec(11, 32'h00000000, 32'hC0400000, 1'b0, 32'hC0400000, 4'b0000);
        set_vec(12, 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);
        set_vec(13, 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
        set_vec(14, 32'h3F800000, 32'hBFC00000, 1'b0, 32'hBF000000, 4'b0000);
        set_vec(15, 32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 4'b0001);
        set_vec(16, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
        set_vec(17, 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000);
        set_vec(18, 32'h40000000, 32'h3FFFFFFF, 1'b1, 32'h34000000, 4'b0000);
        set_vec(19, 32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001);

        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("reset_sum", 64'(bus.SUM), 64'd0);
        check_eq("reset_flags", 64'(bus.flags), 64'd0);
        check_eq("reset_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: op presented in cycle c shows up in cycle c+3.
        @(negedge clk);
        drive_op(0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 check_eq("lat_c1", 64'(bus.out_valid), 64'd0);
        @(negedge clk); #1 check_eq("lat_c2", 64'(bus.out_valid), 64'd0);
        @(negedge clk); #1 check_eq("lat_c3", 64'(bus.out_valid), 64'd1);
        check_eq("lat_result", 64'({bus.flags, bus.SUM}), 64'({4'b0000, 32'h40000000}));

        run_stream(NV, 1'b0, "free");
        run_stream(8, 1'b1, "throttle");

        // Reset with three operations held in the pipe.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_op(k + 3);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1 check_eq("rst_pre_full", 64'(bus.out_valid), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_sum", 64'(bus.SUM), 64'd0);
        check_eq("rst_flags", 64'(bus.flags), 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check_eq("rst_no_stale", 64'(bus.out_valid), 64'd0);
        end
        @(negedge clk);
        drive_op(14);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check_eq("post_rst_valid", 64'(bus.out_valid), 64'd1);
        check_eq("post_rst_result", 64'({bus.flags, bus.SUM}), 64'({vf[14], vs[14]}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
